// File: rtl/mux2_rr_arbiter_pkg.sv
// ============================================================================
//  Module      : mux2_rr_arbiter_pkg
//  Description : Shared state encodings and mux-select constants for the
//                two-requester round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux2_rr_arbiter_pkg;

    localparam int         STATE_W    = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_A = 2'd1;
    localparam logic [1:0] ST_GRANT_B = 2'd2;

    localparam logic       SEL_A      = 1'b0;
    localparam logic       SEL_B      = 1'b1;

    // Select value that corresponds to a grant state; IDLE has no side.
    function automatic logic state_to_sel(input logic [1:0] st, input logic cur_sel);
        logic r;
        r = cur_sel;
        if (st == ST_GRANT_A) begin
            r = SEL_A;
        end else if (st == ST_GRANT_B) begin
            r = SEL_B;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_rr_arbiter_datapath.sv
// ============================================================================
//  Module      : mux2x1 / mux2_rr_arbiter_datapath
//  Description : Single-bit 2:1 mux cell and the WIDTH-bit data select built
//                from one cell per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2x1
    import mux2_rr_arbiter_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = (sel == SEL_B) ? b : a;

endmodule

module mux2_rr_arbiter_datapath #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic             sel,
    output logic [WIDTH-1:0] y_data
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        mux2x1 u_mux (
            .a   (a_data[gi]),
            .b   (b_data[gi]),
            .sel (sel),
            .y   (y_data[gi])
        );
    end

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
//  Module      : mux2_rr_arbiter
//  Description : Round-robin, burst-limited 2:1 merge of two valid/ready
//                requesters into one registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int               CNT_W       = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               r_sel;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_limit;
    logic               w_load_en;
    logic               w_a_fire;
    logic               w_b_fire;
    logic               w_fire;
    logic               w_grant_change;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [WIDTH-1:0]   w_mux_data;

    assign w_load_en      = !r_out_valid || out_ready;
    assign w_a_fire       = a_valid && a_ready;
    assign w_b_fire       = b_valid && b_ready;
    assign w_fire         = w_a_fire || w_b_fire;
    assign w_grant_change = (w_next_state != r_state) && (w_next_state != ST_IDLE);

    // Counter saturates so an uncontested requester can stream indefinitely.
    assign w_cnt_inc = (r_burst_cnt >= c_burst_max) ? r_burst_cnt : r_burst_cnt + c_cnt_one;
    assign w_limit   = w_fire && (w_cnt_inc >= c_burst_max);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= SEL_A;
            r_last_grant <= SEL_B;
            r_burst_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            r_sel   <= state_to_sel(w_next_state, r_sel);
            if (w_next_state != r_state) begin
                r_burst_cnt <= '0;
            end else if (w_fire) begin
                r_burst_cnt <= w_cnt_inc;
            end
            if (w_grant_change) begin
                r_last_grant <= state_to_sel(w_next_state, r_last_grant);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (a_valid && b_valid) begin
                    w_next_state = (r_last_grant == SEL_B) ? ST_GRANT_A : ST_GRANT_B;
                end else if (a_valid) begin
                    w_next_state = ST_GRANT_A;
                end else if (b_valid) begin
                    w_next_state = ST_GRANT_B;
                end
            end
            ST_GRANT_A: begin
                if (b_valid && (!a_valid || w_limit)) begin
                    w_next_state = ST_GRANT_B;
                end else if (!a_valid && !b_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GRANT_B: begin
                if (a_valid && (!b_valid || w_limit)) begin
                    w_next_state = ST_GRANT_A;
                end else if (!a_valid && !b_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        busy    = 1'b0;
        case (r_state)
            ST_GRANT_A: begin
                a_ready = w_load_en;
                busy    = 1'b1;
            end
            ST_GRANT_B: begin
                b_ready = w_load_en;
                busy    = 1'b1;
            end
            default: begin
                busy    = 1'b0;
            end
        endcase
    end

    assign sel = r_sel;

    mux2_rr_arbiter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a_data (a_data),
        .b_data (b_data),
        .sel    (r_sel),
        .y_data (w_mux_data)
    );

    // Output stage: a held beat stays put until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
//  Module      : tb_mux2_rr_arbiter
//  Description : Directed self-checking bench for mux2_rr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       sel;
    logic       busy;

    int         total;
    int         bad;
    int         a_left;
    int         b_left;
    int         a_sent;
    int         b_sent;
    logic [7:0] a_base;
    logic [7:0] b_base;
    int         cyc;
    logic       sel_hist [0:63];
    logic [7:0] log_q [$];

    mux2_rr_arbiter #(
        .WIDTH     (8),
        .BURST_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output beats are captured mid-cycle, ahead of the edge that accepts them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            log_q.push_back(out_data);
        end
    end

    task automatic drive_inputs();
        a_valid = (a_left != 0);
        a_data  = 8'(int'(a_base) + a_sent);
        b_valid = (b_left != 0);
        b_data  = 8'(int'(b_base) + b_sent);
    endtask

    task automatic cycle();
        logic fa;
        logic fb;
        drive_inputs();
        @(negedge clk);
        fa = a_valid && a_ready;
        fb = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (fa) begin
            a_left--;
            a_sent++;
        end
        if (fb) begin
            b_left--;
            b_sent++;
        end
        cyc++;
        if (cyc < 64) sel_hist[cyc] = sel;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        a_left    = 0;
        b_left    = 0;
        a_sent    = 0;
        b_sent    = 0;
        a_base    = 8'h00;
        b_base    = 8'h00;
        out_ready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        log_q.delete();
    endtask

    task automatic check_log(input string name, input logic [7:0] exp [$]);
        total++;
        if (log_q.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_count got=%0d exp=%0d", name, log_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i] !== exp[i]) begin
                bad++;
                $display("FAIL %s_beat%0d got=%h exp=%h", name, i, log_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, sel, busy, out_data} !== 11'h000) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", {out_valid, sel, busy, out_data}, 11'h000);
        end
        b_base = 8'h90;
        b_left = 3;
        cycle();
        cycle();
        total++;
        if ({out_valid, sel, busy} !== 3'b111) begin
            bad++;
            $display("FAIL reset_prebeat got=%b exp=111", {out_valid, sel, busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, sel, busy, b_ready, out_data} !== 12'h000) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", {out_valid, sel, busy, b_ready, out_data}, 12'h000);
        end
    endtask

    task automatic test_a_only();
        logic [7:0] exp [$];
        do_reset();
        a_base = 8'h11;
        a_left = 5;
        drive_inputs();
        #1;
        total++;
        if (a_ready !== 1'b0) begin
            bad++;
            $display("FAIL aonly_idle_ready got=%b exp=0", a_ready);
        end
        cycle();
        total++;
        if ({busy, sel, out_valid} !== 3'b100) begin
            bad++;
            $display("FAIL aonly_grant got=%b exp=100", {busy, sel, out_valid});
        end
        cycle();
        total++;
        if ({out_valid, out_data} !== {1'b1, 8'h11}) begin
            bad++;
            $display("FAIL aonly_first got=%b/%h exp=1/11", out_valid, out_data);
        end
        repeat (5) begin
            cycle();
            total++;
            if (sel !== 1'b0) begin
                bad++;
                $display("FAIL aonly_sel got=%b exp=0", sel);
            end
        end
        exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_log("aonly", exp);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL aonly_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [$];
        do_reset();
        a_base = 8'hA0;
        b_base = 8'hB0;
        a_left = 8;
        b_left = 8;
        repeat (18) cycle();
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        check_log("rr", exp);
        total++;
        if ({sel_hist[1], sel_hist[4], sel_hist[5], sel_hist[8],
             sel_hist[9], sel_hist[12], sel_hist[13]} !== 7'b0011001) begin
            bad++;
            $display("FAIL rr_sel_seq got=%b exp=0011001",
                     {sel_hist[1], sel_hist[4], sel_hist[5], sel_hist[8],
                      sel_hist[9], sel_hist[12], sel_hist[13]});
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [$];
        do_reset();
        a_base = 8'h30;
        a_left = 6;
        repeat (3) cycle();
        total++;
        if ({out_valid, out_data} !== {1'b1, 8'h31}) begin
            bad++;
            $display("FAIL stall_pre got=%b/%h exp=1/31", out_valid, out_data);
        end
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            total++;
            if ({a_ready, b_ready} !== 2'b00) begin
                bad++;
                $display("FAIL stall_ready got=%b exp=00", {a_ready, b_ready});
            end
            cycle();
            total++;
            if ({out_valid, out_data} !== {1'b1, 8'h31}) begin
                bad++;
                $display("FAIL stall_hold got=%b/%h exp=1/31", out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        repeat (8) cycle();
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        check_log("stall", exp);
    endtask

    task automatic test_b_drop();
        logic [7:0] exp [$];
        do_reset();
        a_base = 8'h50;
        b_base = 8'h60;
        b_left = 2;
        cycle();
        a_left = 4;
        cycle();
        cycle();
        total++;
        if ({sel, dut.r_burst_cnt} !== {1'b1, 3'd2}) begin
            bad++;
            $display("FAIL bdrop_pre got=%b/%0d exp=1/2", sel, dut.r_burst_cnt);
        end
        cycle();
        total++;
        if ({sel, busy, dut.r_burst_cnt} !== {1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL bdrop_switch got=%b/%b/%0d exp=0/1/0", sel, busy, dut.r_burst_cnt);
        end
        repeat (5) cycle();
        exp = '{8'h60, 8'h61, 8'h50, 8'h51, 8'h52, 8'h53};
        check_log("bdrop", exp);
    endtask

    // Continues from test_b_drop: A was the last side served.
    task automatic test_idle_rearb();
        logic [7:0] exp [$];
        total++;
        if ({busy, sel} !== 2'b00) begin
            bad++;
            $display("FAIL idle_state got=%b exp=00", {busy, sel});
        end
        log_q.delete();
        a_base = 8'h70;
        b_base = 8'h80;
        a_sent = 0;
        b_sent = 0;
        a_left = 1;
        b_left = 1;
        cycle();
        total++;
        if ({busy, sel} !== 2'b11) begin
            bad++;
            $display("FAIL idle_rearb got=%b exp=11", {busy, sel});
        end
        repeat (5) cycle();
        exp = '{8'h80, 8'h70};
        check_log("rearb", exp);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        a_left    = 0;
        b_left    = 0;
        a_sent    = 0;
        b_sent    = 0;
        a_base    = 8'h00;
        b_base    = 8'h00;
        drive_inputs();
        test_reset();
        test_a_only();
        test_round_robin();
        test_stall();
        test_b_drop();
        test_idle_rearb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
